// File: rtl/mem_arbiter_ctrl_if.sv
// Bundle of the requester-side ports and the single-beat AXI4 master ports.
// The master modport is the arbiter's view. The slave modport is the environment's view (requesters and AXI slave).
interface mem_arbiter_ctrl_if #(
  parameter int NCH        = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NCH-1:0]            RECEIVE_ADDR_VALID;
  logic [NCH*ADDR_WIDTH-1:0] RECEIVE_ADDR;
  logic [NCH-1:0]            RECEIVE_DATA_VALID;
  logic [NCH*DATA_WIDTH-1:0] RECEIVE_DATA;
  logic [NCH-1:0]            RECEIVE_READY;
  logic [NCH-1:0]            SEND_VALID;
  logic [DATA_WIDTH-1:0]     SEND_DATA;
  logic                      SEND_ERR;
  logic [NCH-1:0]            SEND_READY;

  logic [ADDR_WIDTH-1:0]     ARADDR;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;
  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic                      WVALID;
  logic                      WLAST;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;

  modport master (
    input  RECEIVE_ADDR_VALID, RECEIVE_ADDR, RECEIVE_DATA_VALID, RECEIVE_DATA, SEND_READY,
           ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID,
    output RECEIVE_READY, SEND_VALID, SEND_DATA, SEND_ERR,
           ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, WLAST, BREADY
  );

  modport slave (
    output RECEIVE_ADDR_VALID, RECEIVE_ADDR, RECEIVE_DATA_VALID, RECEIVE_DATA, SEND_READY,
           ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID,
    input  RECEIVE_READY, SEND_VALID, SEND_DATA, SEND_ERR,
           ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, WLAST, BREADY
  );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Round-robin arbiter that lets NCH request/response channels share one single-beat AXI4 master.
// Only one transaction is in flight at a time. A write completes only after its B response.
module mem_arbiter_ctrl #(
  parameter int NCH        = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  mem_arbiter_ctrl_if.master bus
);
  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR      = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;

  logic [2:0]            r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_send_data;
  logic                  r_err;
  logic                  r_aw_pend;
  logic                  r_w_pend;

  logic [PTR_W-1:0]      w_grant;
  logic                  w_grant_any;
  logic [NCH-1:0]        w_grant_oh;
  logic [NCH-1:0]        w_owner_oh;
  logic [PTR_W-1:0]      w_next_ptr;
  logic                  w_aw_done;
  logic                  w_w_done;
  logic                  w_send_ack;
  logic                  w_unused_ok;

  // NOTE: a combinational block assigns every output before any branch, so no latch is inferred.
  always_comb begin
    logic [PTR_W:0] v_idx;
    v_idx       = '0;
    w_grant     = '0;
    w_grant_any = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      v_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (v_idx >= (PTR_W+1)'(NCH)) v_idx = v_idx - (PTR_W+1)'(NCH);
      if (!w_grant_any && bus.RECEIVE_ADDR_VALID[v_idx[PTR_W-1:0]]) begin
        w_grant     = v_idx[PTR_W-1:0];
        w_grant_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_grant_oh = '0;
    w_owner_oh = '0;
    for (int i = 0; i < NCH; i++) begin
      w_grant_oh[i] = w_grant_any && (w_grant == PTR_W'(i));
      w_owner_oh[i] = (r_owner == PTR_W'(i));
    end
  end

  assign w_next_ptr  = (w_grant == PTR_W'(NCH-1)) ? '0 : w_grant + 1'b1;
  assign w_aw_done   = !r_aw_pend || bus.AWREADY;
  assign w_w_done    = !r_w_pend  || bus.WREADY;
  assign w_send_ack  = |(bus.SEND_READY & w_owner_oh);
  assign w_unused_ok = ^{bus.RRESP[0], bus.BRESP[0]};

  assign bus.RECEIVE_READY = (r_state == ST_IDLE) ? w_grant_oh : '0;
  assign bus.SEND_VALID    = (r_state == ST_RESP) ? w_owner_oh : '0;
  assign bus.SEND_DATA     = r_send_data;
  assign bus.SEND_ERR      = r_err;
  assign bus.ARADDR        = r_addr;
  assign bus.ARVALID       = (r_state == ST_RD_ADDR);
  assign bus.RREADY        = (r_state == ST_RD_DATA);
  assign bus.AWADDR        = r_addr;
  assign bus.AWVALID       = r_aw_pend;
  assign bus.WDATA         = r_wdata;
  assign bus.WVALID        = r_w_pend;
  assign bus.WLAST         = r_w_pend;
  assign bus.BREADY        = (r_state == ST_WR_RESP);

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_send_data <= '0;
      r_err       <= 1'b0;
      r_aw_pend   <= 1'b0;
      r_w_pend    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_owner <= w_grant;
            r_ptr   <= w_next_ptr;
            r_addr  <= bus.RECEIVE_ADDR[int'(w_grant)*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata <= bus.RECEIVE_DATA[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
            if (bus.RECEIVE_DATA_VALID[w_grant]) begin
              r_state   <= ST_WR;
              r_aw_pend <= 1'b1;
              r_w_pend  <= 1'b1;
            end else begin
              r_state <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: if (bus.ARREADY) r_state <= ST_RD_DATA;
        ST_RD_DATA: begin
          if (bus.RVALID) begin
            r_send_data <= bus.RDATA;
            r_err       <= bus.RRESP[1];
            r_state     <= ST_RESP;
          end
        end
        ST_WR: begin
          // AW and W retire independently; leave only once both have handshaken.
          if (bus.AWREADY) r_aw_pend <= 1'b0;
          if (bus.WREADY)  r_w_pend  <= 1'b0;
          if (w_aw_done && w_w_done) r_state <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (bus.BVALID) begin
            r_send_data <= r_wdata;
            r_err       <= bus.BRESP[1];
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: if (w_send_ack) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench: the bench plays the requesters and a memory-backed AXI slave with programmable waits.
// Expected data comes from a reference memory, and expected grants come from the round-robin rule.
module tb_mem_arbiter_ctrl;
  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  mem_arbiter_ctrl_if #(.NCH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mem_arbiter_ctrl #(.NCH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  int checks     = 0;
  int errors     = 0;
  int cyc_cnt    = 0;
  int rr_ptr     = 0;
  int accept_cyc = 0;
  int last_lat   = 0;

  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];
  logic        req_wr    [NCH];
  logic [31:0] req_addr  [NCH];
  logic [31:0] req_data  [NCH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
    cyc_cnt++;
  endtask

  function automatic int predict_grant(input logic [NCH-1:0] v);
    for (int k = 0; k < NCH; k++) begin
      if (v[(rr_ptr + k) % NCH]) return (rr_ptr + k) % NCH;
    end
    return 0;
  endfunction

  task automatic drive_req(input int ch, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    req_wr[ch]                         = wr;
    req_addr[ch]                       = addr;
    req_data[ch]                       = data;
    bus.RECEIVE_ADDR[ch*AW +: AW]      = addr;
    bus.RECEIVE_DATA[ch*DW +: DW]      = data;
    bus.RECEIVE_DATA_VALID[ch]         = wr;
    bus.RECEIVE_ADDR_VALID[ch]         = 1'b1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rdy_vld"}, {bus.RECEIVE_READY, bus.SEND_VALID}, '0);
    check({tag, "_send_data"}, bus.SEND_DATA, '0);
    check({tag, "_araddr"}, bus.ARADDR, '0);
    check({tag, "_awaddr"}, bus.AWADDR, '0);
    check({tag, "_wdata"}, bus.WDATA, '0);
    check({tag, "_ctl"}, {bus.SEND_ERR, bus.ARVALID, bus.RREADY, bus.AWVALID,
                          bus.WVALID, bus.WLAST, bus.BREADY}, '0);
  endtask

  // Serve one request from channel ch, which the caller has already posted, from grant through response.
  task automatic serve(input int ch, input int aw_dly, input int w_dly, input int ar_dly,
                       input int r_dly, input int b_dly, input int send_dly, input bit err);
    logic [NCH-1:0] oh;
    logic [31:0]    exp_data;
    logic [31:0]    seen_addr;
    logic [31:0]    seen_data;
    int             k;
    bit             done;
    bit             aw_done;
    bit             w_done;
    oh      = '0;
    oh[ch]  = 1'b1;
    seen_addr = '0;
    seen_data = '0;
    #1;
    k = 0;
    while (bus.RECEIVE_READY == '0 && k < 50) begin cyc(); k++; end
    check("grant_wait", k < 50, 1);
    check("grant", bus.RECEIVE_READY, oh);
    accept_cyc = cyc_cnt;
    cyc();
    bus.RECEIVE_ADDR_VALID[ch] = 1'b0;
    rr_ptr = (ch + 1) % NCH;

    if (req_wr[ch]) begin
      aw_done = 0; w_done = 0; k = 0;
      while (!(aw_done && w_done) && k < 100) begin
        bus.AWREADY = !aw_done && (k >= aw_dly);
        bus.WREADY  = !w_done  && (k >= w_dly);
        #1;
        check("awvalid", bus.AWVALID, !aw_done);
        check("wvalid", bus.WVALID, !w_done);
        check("wlast", bus.WLAST, !w_done);
        check("bready_early", bus.BREADY, 0);
        if (bus.AWVALID && bus.AWREADY) begin
          check("awaddr", bus.AWADDR, req_addr[ch]);
          seen_addr = bus.AWADDR;
          aw_done   = 1;
        end
        if (bus.WVALID && bus.WREADY) begin
          check("wdata", bus.WDATA, req_data[ch]);
          seen_data = bus.WDATA;
          w_done    = 1;
        end
        cyc(); k++;
      end
      bus.AWREADY = 1'b0;
      bus.WREADY  = 1'b0;
      check("wr_wait", aw_done && w_done, 1);
      slave_mem[seen_addr] = seen_data;
      done = 0; k = 0;
      while (!done && k < 100) begin
        bus.BVALID = (k >= b_dly);
        bus.BRESP  = err ? 2'b10 : 2'b00;
        #1;
        check("bready", bus.BREADY, 1);
        done = bus.BVALID;
        cyc(); k++;
      end
      bus.BVALID = 1'b0;
      bus.BRESP  = 2'b00;
      exp_data   = req_data[ch];
    end else begin
      done = 0; k = 0;
      while (!done && k < 100) begin
        bus.ARREADY = (k >= ar_dly);
        #1;
        check("arvalid", bus.ARVALID, 1);
        check("araddr", bus.ARADDR, req_addr[ch]);
        seen_addr = bus.ARADDR;
        done = bus.ARREADY;
        cyc(); k++;
      end
      bus.ARREADY = 1'b0;
      done = 0; k = 0;
      while (!done && k < 100) begin
        bus.RVALID = (k >= r_dly);
        bus.RDATA  = bus.RVALID ? (slave_mem.exists(seen_addr) ? slave_mem[seen_addr] : 32'h0) : $urandom;
        bus.RRESP  = err ? 2'b10 : 2'b00;
        #1;
        check("rready", bus.RREADY, 1);
        check("arvalid_off", bus.ARVALID, 0);
        done = bus.RVALID;
        cyc(); k++;
      end
      bus.RVALID = 1'b0;
      bus.RRESP  = 2'b00;
      exp_data   = ref_mem.exists(req_addr[ch]) ? ref_mem[req_addr[ch]] : 32'h0;
    end

    for (int j = 0; j <= send_dly; j++) begin
      bus.SEND_READY = (j == send_dly) ? '1 : ~oh;
      #1;
      if (j == 0) last_lat = cyc_cnt - accept_cyc;
      check("send_valid", bus.SEND_VALID, oh);
      check("send_data", bus.SEND_DATA, exp_data);
      check("send_err", bus.SEND_ERR, err);
      check("no_grant_in_resp", bus.RECEIVE_READY, '0);
      cyc();
    end
    bus.SEND_READY = '0;
    if (req_wr[ch]) ref_mem[req_addr[ch]] = req_data[ch];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ch;
    int ch_a;
    int ch_b;
    ARESETN                = 1'b0;
    bus.RECEIVE_ADDR_VALID = '0;
    bus.RECEIVE_ADDR       = '0;
    bus.RECEIVE_DATA_VALID = '0;
    bus.RECEIVE_DATA       = '0;
    bus.SEND_READY         = '0;
    bus.ARREADY            = 1'b0;
    bus.RDATA              = '0;
    bus.RRESP              = 2'b00;
    bus.RVALID             = 1'b0;
    bus.AWREADY            = 1'b0;
    bus.WREADY             = 1'b0;
    bus.BRESP              = 2'b00;
    bus.BVALID             = 1'b0;
    cyc(); cyc();
    check_reset_outs("por");
    ARESETN = 1'b1;
    cyc();
    check_reset_outs("idle");

    // Four simultaneous reads starting from pointer 0, then ch0 re-requests and must wait for ch3.
    for (int i = 0; i < NCH; i++) drive_req(i, 1'b0, 32'h40 + 32'(i) * 4, 32'h0);
    serve(0, 0, 0, 0, 0, 0, 0, 0);
    drive_req(0, 1'b0, 32'h80, 32'h0);
    serve(1, 0, 0, 0, 0, 0, 0, 0);
    serve(2, 0, 0, 1, 2, 0, 0, 0);
    serve(3, 0, 0, 0, 0, 0, 0, 0);
    serve(0, 0, 0, 0, 0, 0, 0, 0);

    // Single channel write, then read back with a zero-wait slave.
    drive_req(0, 1'b1, 32'h100, 32'hDEADBEEF);
    serve(0, 0, 0, 0, 0, 0, 0, 0);
    drive_req(0, 1'b0, 32'h100, 32'h0);
    serve(0, 0, 0, 0, 0, 0, 0, 0);
    check("rd_latency", last_lat, 3);

    // AWREADY late, WREADY immediate.
    drive_req(1, 1'b1, 32'h200, 32'hCAFEF00D);
    serve(1, 5, 0, 0, 0, 2, 0, 0);

    // Error response on one read only.
    drive_req(3, 1'b0, 32'h100, 32'h0);
    serve(3, 0, 0, 0, 0, 0, 0, 1);
    drive_req(3, 1'b0, 32'h200, 32'h0);
    serve(3, 0, 0, 0, 0, 0, 0, 0);

    // Owner withholds SEND_READY for 10 cycles while another channel waits.
    drive_req(1, 1'b1, 32'h300, 32'h12345678);
    drive_req(2, 1'b0, 32'h300, 32'h0);
    ch = predict_grant(bus.RECEIVE_ADDR_VALID);
    serve(ch, 0, 0, 0, 0, 0, 10, 0);
    ch = predict_grant(bus.RECEIVE_ADDR_VALID);
    serve(ch, 0, 0, 0, 0, 0, 0, 0);

    // Reset pulse while the read-data phase is open.
    drive_req(2, 1'b0, 32'h100, 32'h0);
    #1;
    check("mrst_grant", bus.RECEIVE_READY, 4'b0100);
    cyc();
    bus.RECEIVE_ADDR_VALID[2] = 1'b0;
    bus.ARREADY = 1'b1;
    #1;
    check("mrst_arvalid", bus.ARVALID, 1);
    cyc();
    bus.ARREADY = 1'b0;
    #1;
    check("mrst_rready", bus.RREADY, 1);
    ARESETN = 1'b0;
    #1;
    check_reset_outs("mrst");
    cyc();
    ARESETN = 1'b1;
    rr_ptr  = 0;
    cyc();
    check_reset_outs("mrst_idle");

    // Random write/read pairs posted concurrently on two channels with random slave waits.
    for (int it = 0; it < 50; it++) begin
      ch_a = $urandom_range(0, NCH-1);
      ch_b = (ch_a + 1 + $urandom_range(0, NCH-2)) % NCH;
      drive_req(ch_a, 1'b1, 32'h1000 + 32'($urandom_range(0, 7)) * 4, $urandom);
      drive_req(ch_b, 1'b0, 32'h1000 + 32'($urandom_range(0, 7)) * 4, 32'h0);
      for (int n = 0; n < 2; n++) begin
        ch = predict_grant(bus.RECEIVE_ADDR_VALID);
        serve(ch, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
              ($urandom_range(0, 7) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
